uart_alu_ctrl: RTL and testbench

Frame controller between the UART receiver, the ALU and the UART transmitter. It collects a three-byte command frame (operand A, operand B, opcode) and validates the opcode. It fires the ALU for one cycle, captures the result and hands it to the UART transmitter as a single reply byte. Compared with the first-generation interface it adds parametrised widths, opcode checking, an inter-byte timeout, result return over TX and error/overrun reporting.

---
 rtl/uart_alu_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_uart_alu_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: frame controller between UART RX, the ALU and UART TX.
// Collects operand A, operand B and opcode, fires the ALU, returns the result.
module uart_alu_ctrl #(
    parameter int NB_DATA     = 8,
    parameter int NB_OP       = 6,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic               o_alu_valid,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic [3:0]         o_leds,
    output logic [1:0]         o_err,
    output logic               o_overrun
);

    localparam int            CW       = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_EXEC,
        S_CAPTURE,
        S_TX,
        S_TX_WAIT
    } state_t;

    state_t             state;
    state_t             state_n;
    logic               rx_prev;
    logic               tx_prev;
    logic               rx_evt;
    logic               tx_evt;
    logic               op_legal;
    logic               hi_zero;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_n;
    logic [NB_DATA-1:0] a_n;
    logic [NB_DATA-1:0] b_n;
    logic [NB_DATA-1:0] txd_n;
    logic [NB_OP-1:0]   op_n;
    logic [1:0]         err_n;
    logic               ovr_n;

    assign rx_evt = i_rx_done & ~rx_prev;
    assign tx_evt = i_tx_done & ~tx_prev;

    // Opcode check: upper bits clear and low bits in the supported set.
    always_comb begin
        hi_zero  = ((i_rx_data >> NB_OP) == '0);
        op_legal = 1'b0;
        case (i_rx_data[NB_OP-1:0])
            NB_OP'(6'b100000),
            NB_OP'(6'b100010),
            NB_OP'(6'b100100),
            NB_OP'(6'b100101),
            NB_OP'(6'b100110),
            NB_OP'(6'b100111),
            NB_OP'(6'b000011),
            NB_OP'(6'b000010): op_legal = hi_zero;
            default:           op_legal = 1'b0;
        endcase
    end

    // Next-state, datapath updates and one-cycle pulses.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        a_n         = o_data_a;
        b_n         = o_data_b;
        op_n        = o_op;
        txd_n       = o_tx_data;
        err_n       = o_err;
        ovr_n       = o_overrun;
        o_alu_valid = 1'b0;
        o_tx_start  = 1'b0;
        unique case (state)
            S_WAIT_A: begin
                cnt_n = '0;
                if (rx_evt) begin
                    a_n     = i_rx_data;
                    err_n   = 2'b00;
                    ovr_n   = 1'b0;
                    state_n = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (rx_evt) begin
                    b_n     = i_rx_data;
                    cnt_n   = '0;
                    state_n = S_WAIT_OP;
                end else if (cnt == CNT_LAST) begin
                    err_n[1] = 1'b1;
                    cnt_n    = '0;
                    state_n  = S_WAIT_A;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_WAIT_OP: begin
                if (rx_evt) begin
                    cnt_n = '0;
                    if (op_legal) begin
                        op_n    = i_rx_data[NB_OP-1:0];
                        state_n = S_EXEC;
                    end else begin
                        err_n[0] = 1'b1;
                        state_n  = S_WAIT_A;
                    end
                end else if (cnt == CNT_LAST) begin
                    err_n[1] = 1'b1;
                    cnt_n    = '0;
                    state_n  = S_WAIT_A;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_EXEC: begin
                o_alu_valid = 1'b1;
                if (rx_evt) ovr_n = 1'b1;
                state_n = S_CAPTURE;
            end
            S_CAPTURE: begin
                txd_n = i_alu_result;
                if (rx_evt) ovr_n = 1'b1;
                state_n = S_TX;
            end
            S_TX: begin
                o_tx_start = 1'b1;
                if (rx_evt) ovr_n = 1'b1;
                state_n = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (rx_evt) ovr_n = 1'b1;
                if (tx_evt) state_n = S_WAIT_A;
            end
            default: begin
                cnt_n   = '0;
                state_n = S_WAIT_A;
            end
        endcase
    end

    // State display on the LEDs.
    always_comb begin
        o_leds = 4'b1000;
        unique case (state)
            S_WAIT_A:  o_leds = 4'b0001;
            S_WAIT_B:  o_leds = 4'b0010;
            S_WAIT_OP: o_leds = 4'b0100;
            default:   o_leds = 4'b1000;
        endcase
    end

    // Registered state, operands, reply byte, flags and edge detectors.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state     <= S_WAIT_A;
            cnt       <= '0;
            rx_prev   <= 1'b0;
            tx_prev   <= 1'b0;
            o_data_a  <= '0;
            o_data_b  <= '0;
            o_op      <= '0;
            o_tx_data <= '0;
            o_err     <= 2'b00;
            o_overrun <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rx_prev   <= i_rx_done;
            tx_prev   <= i_tx_done;
            o_data_a  <= a_n;
            o_data_b  <= b_n;
            o_op      <= op_n;
            o_tx_data <= txd_n;
            o_err     <= err_n;
            o_overrun <= ovr_n;
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb_uart_alu_ctrl: scenario tasks plus randomized frames
// checked against a frame-level reference model.
module tb_uart_alu_ctrl;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_done = 1'b0;
    logic [7:0] i_alu_result;
    logic       i_tx_done = 1'b0;
    logic [7:0] o_data_a;
    logic [7:0] o_data_b;
    logic [5:0] o_op;
    logic       o_alu_valid;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic [3:0] o_leds;
    logic [1:0] o_err;
    logic       o_overrun;

    int vectors = 0;
    int miscompares = 0;
    logic [5:0] exp_op = 6'h00;
    logic [7:0] exp_tx = 8'h00;
    logic [7:0] legal_ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25,
                                  8'h26, 8'h27, 8'h03, 8'h02};

    uart_alu_ctrl #(
        .NB_DATA    (8),
        .NB_OP      (6),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_rx_data   (i_rx_data),
        .i_rx_done   (i_rx_done),
        .i_alu_result(i_alu_result),
        .i_tx_done   (i_tx_done),
        .o_data_a    (o_data_a),
        .o_data_b    (o_data_b),
        .o_op        (o_op),
        .o_alu_valid (o_alu_valid),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .o_leds      (o_leds),
        .o_err       (o_err),
        .o_overrun   (o_overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [7:0] a,
                                             input logic [7:0] b,
                                             input logic [7:0] op);
        case (op)
            8'h20:   return a + b;
            8'h22:   return a - b;
            8'h24:   return a & b;
            8'h25:   return a | b;
            8'h26:   return a ^ b;
            8'h27:   return ~(a | b);
            8'h03:   return 8'($signed(a) >>> b);
            8'h02:   return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit is_legal(input logic [7:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    always_comb i_alu_result = alu_model(o_data_a, o_data_b, {2'b00, o_op});

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        i_rx_data = b;
        i_rx_done = 1'b1;
        repeat (hold) step();
        i_rx_done = 1'b0;
        step();
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input int hold);
        logic [7:0] exp_r;
        int nv;
        int nt;
        exp_r = alu_model(a, b, op);
        nv = 0;
        nt = 0;
        i_rx_data = op;
        i_rx_done = 1'b1;
        for (int c = 1; c <= hold + 4; c++) begin
            step();
            if (c >= hold) i_rx_done = 1'b0;
            @(negedge clk);
            if (o_alu_valid) nv++;
            if (o_tx_start) nt++;
            if (c == 1) begin
                vectors++;
                if (o_alu_valid !== 1'b1 || o_op !== op[5:0] ||
                    o_data_a !== a || o_data_b !== b) begin
                    miscompares++;
                    $display("FAIL exec_e1: valid=%b a=%h b=%h op=%h required 1 %h %h %h",
                             o_alu_valid, o_data_a, o_data_b, o_op, a, b, op[5:0]);
                end
            end
            if (c == 3) begin
                vectors++;
                if (o_tx_start !== 1'b1 || o_tx_data !== exp_r) begin
                    miscompares++;
                    $display("FAIL tx_e3: start=%b data=%h required 1 %h",
                             o_tx_start, o_tx_data, exp_r);
                end
            end
        end
        vectors++;
        if (nv != 1 || nt != 1) begin
            miscompares++;
            $display("FAIL pulse_count: valid=%0d start=%0d required 1 1", nv, nt);
        end
        vectors++;
        if (o_leds !== 4'b1000 || o_tx_data !== exp_r) begin
            miscompares++;
            $display("FAIL tx_wait: leds=%b data=%h required 1000 %h",
                     o_leds, o_tx_data, exp_r);
        end
        exp_op = op[5:0];
        exp_tx = exp_r;
    endtask

    task automatic finish_tx();
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        step();
        vectors++;
        if (o_leds !== 4'b0001) begin
            miscompares++;
            $display("FAIL tx_done_idle: leds=%b required 0001", o_leds);
        end
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input int hold);
        send_byte(a, hold);
        vectors++;
        if (o_data_a !== a || o_leds !== 4'b0010 ||
            o_err !== 2'b00 || o_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL byte_a: a=%h leds=%b err=%b ovr=%b required %h 0010 00 0",
                     o_data_a, o_leds, o_err, o_overrun, a);
        end
        send_byte(b, hold);
        vectors++;
        if (o_data_b !== b || o_leds !== 4'b0100) begin
            miscompares++;
            $display("FAIL byte_b: b=%h leds=%b required %h 0100",
                     o_data_b, o_leds, b);
        end
        run_op(a, b, op, hold);
    endtask

    task automatic bad_frame(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op);
        int nv;
        int nt;
        nv = 0;
        nt = 0;
        send_byte(a, 1);
        send_byte(b, 1);
        i_rx_data = op;
        i_rx_done = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            i_rx_done = 1'b0;
            @(negedge clk);
            if (o_alu_valid) nv++;
            if (o_tx_start) nt++;
        end
        vectors++;
        if (nv != 0 || nt != 0) begin
            miscompares++;
            $display("FAIL bad_op_pulses: valid=%0d start=%0d required 0 0", nv, nt);
        end
        vectors++;
        if (o_err !== 2'b01 || o_op !== exp_op ||
            o_leds !== 4'b0001 || o_tx_data !== exp_tx) begin
            miscompares++;
            $display("FAIL bad_op_state: err=%b op=%h leds=%b tx=%h required 01 %h 0001 %h",
                     o_err, o_op, o_leds, o_tx_data, exp_op, exp_tx);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        step();
        step();
        vectors++;
        if (o_data_a !== 8'h00 || o_data_b !== 8'h00 || o_op !== 6'h00 ||
            o_tx_data !== 8'h00 || o_alu_valid !== 1'b0 ||
            o_tx_start !== 1'b0 || o_err !== 2'b00 ||
            o_overrun !== 1'b0 || o_leds !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset: a=%h b=%h op=%h tx=%h v=%b s=%b err=%b ovr=%b leds=%b required all zero leds 0001",
                     o_data_a, o_data_b, o_op, o_tx_data, o_alu_valid,
                     o_tx_start, o_err, o_overrun, o_leds);
        end
        i_rst = 1'b0;
        step();
        exp_op = 6'h00;
        exp_tx = 8'h00;
    endtask

    task automatic test_add();
        run_frame(8'h05, 8'h03, 8'h20, 1);
        vectors++;
        if (o_tx_data !== 8'h08) begin
            miscompares++;
            $display("FAIL add_reply: got %h required 08", o_tx_data);
        end
        finish_tx();
    endtask

    task automatic test_sub_held();
        run_frame(8'h03, 8'h05, 8'h22, 10);
        vectors++;
        if (o_tx_data !== 8'hFE || o_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_held: tx=%h ovr=%b required FE 0", o_tx_data, o_overrun);
        end
        finish_tx();
    endtask

    task automatic test_bad_op();
        bad_frame(8'h01, 8'h02, 8'h3F);
        bad_frame(8'h01, 8'h02, 8'h60);
        run_frame(8'h11, 8'h22, 8'h24, 1);
        finish_tx();
    endtask

    task automatic test_timeout();
        send_byte(8'h77, 1);
        repeat (TO - 2) step();
        @(negedge clk);
        vectors++;
        if (o_err !== 2'b00 || o_leds !== 4'b0010) begin
            miscompares++;
            $display("FAIL timeout_early: err=%b leds=%b required 00 0010", o_err, o_leds);
        end
        step();
        vectors++;
        if (o_err !== 2'b10 || o_leds !== 4'b0001 || o_data_a !== 8'h77) begin
            miscompares++;
            $display("FAIL timeout_fire: err=%b leds=%b a=%h required 10 0001 77",
                     o_err, o_leds, o_data_a);
        end
        run_frame(8'h0F, 8'hF0, 8'h25, 1);
        vectors++;
        if (o_tx_data !== 8'hFF) begin
            miscompares++;
            $display("FAIL timeout_recover: got %h required FF", o_tx_data);
        end
        finish_tx();
        send_byte(8'h31, 1);
        repeat (TO - 2) step();
        send_byte(8'h13, 1);
        vectors++;
        if (o_err !== 2'b00 || o_leds !== 4'b0100 || o_data_b !== 8'h13) begin
            miscompares++;
            $display("FAIL timeout_race: err=%b leds=%b b=%h required 00 0100 13",
                     o_err, o_leds, o_data_b);
        end
        run_op(8'h31, 8'h13, 8'h24, 1);
        finish_tx();
    endtask

    task automatic test_overrun();
        run_frame(8'h40, 8'h02, 8'h02, 1);
        step();
        send_byte(8'hAA, 1);
        vectors++;
        if (o_overrun !== 1'b1 || o_leds !== 4'b1000 ||
            o_data_a !== 8'h40 || o_tx_data !== 8'h10) begin
            miscompares++;
            $display("FAIL overrun: ovr=%b leds=%b a=%h tx=%h required 1 1000 40 10",
                     o_overrun, o_leds, o_data_a, o_tx_data);
        end
        finish_tx();
        vectors++;
        if (o_overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sticky: got %b required 1", o_overrun);
        end
        run_frame(8'h81, 8'h01, 8'h03, 1);
        finish_tx();
    endtask

    task automatic test_reset_mid();
        send_byte(8'h12, 1);
        send_byte(8'h34, 1);
        i_rst = 1'b1;
        i_rx_data = 8'h5A;
        i_rx_done = 1'b1;
        step();
        i_rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (o_data_a !== 8'h00 || o_data_b !== 8'h00 || o_op !== 6'h00 ||
            o_tx_data !== 8'h00 || o_alu_valid !== 1'b0 ||
            o_tx_start !== 1'b0 || o_err !== 2'b00 ||
            o_overrun !== 1'b0 || o_leds !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_mid: a=%h b=%h op=%h tx=%h v=%b s=%b err=%b ovr=%b leds=%b required all zero leds 0001",
                     o_data_a, o_data_b, o_op, o_tx_data, o_alu_valid,
                     o_tx_start, o_err, o_overrun, o_leds);
        end
        exp_op = 6'h00;
        exp_tx = 8'h00;
        step();
        vectors++;
        if (o_data_a !== 8'h5A || o_leds !== 4'b0010) begin
            miscompares++;
            $display("FAIL stale_rx: a=%h leds=%b required 5A 0010", o_data_a, o_leds);
        end
        i_rx_done = 1'b0;
        step();
        send_byte(8'h06, 1);
        run_op(8'h5A, 8'h06, 8'h26, 1);
        finish_tx();
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        int hold;
        for (int n = 0; n < 30; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 3) == 0) op = 8'($urandom_range(0, 255));
            else op = legal_ops[$urandom_range(0, 7)];
            hold = $urandom_range(1, 3);
            if (is_legal(op)) begin
                run_frame(a, b, op, hold);
                finish_tx();
            end else begin
                bad_frame(a, b, op);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_sub_held();
        test_bad_op();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
